// File: rtl/uart_result_tx_if.sv
// -----------------------------------------------------------------------------
// uart_result_tx_if
//   Bundles the snapshot request handshake, the observed CPU payload and the
//   serial/status outputs of uart_result_tx.
//
//   send_valid   requester -> tx   request to send one snapshot frame
//   send_ready   tx -> requester   idle and able to accept a request
//   result_high  requester -> tx   ALU result upper half (16 bits)
//   result_low   requester -> tx   ALU result lower half (16 bits)
//   operand_p    requester -> tx   ALU operand P (16 bits)
//   flags        requester -> tx   CPU flag bits (5 bits)
//   halt         requester -> tx   CPU halted indicator
//   tx           tx -> line        serial output, idles high
//   busy         tx -> requester   frame being shifted out
//   frame_done   tx -> requester   one-cycle pulse after the final stop bit
//
//   master: the side that requests snapshots and watches the line.
//   slave : the transmitter itself.
// -----------------------------------------------------------------------------
interface uart_result_tx_if;
    logic        send_valid;
    logic        send_ready;
    logic [15:0] result_high;
    logic [15:0] result_low;
    logic [15:0] operand_p;
    logic [4:0]  flags;
    logic        halt;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (
        output send_valid,
        output result_high,
        output result_low,
        output operand_p,
        output flags,
        output halt,
        input  send_ready,
        input  tx,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  send_valid,
        input  result_high,
        input  result_low,
        input  operand_p,
        input  flags,
        input  halt,
        output send_ready,
        output tx,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/uart_result_tx.sv
// -----------------------------------------------------------------------------
// uart_result_tx
//   UART 8N1 transmitter carrying CPU observation snapshots back to the host.
//   Each accepted request latches the payload into a 9-byte frame and shifts
//   it out back-to-back:
//     A5, res_hi[15:8], res_hi[7:0], res_lo[15:8], res_lo[7:0],
//     op_p[15:8], op_p[7:0], {2'b00, halt, flags}, XOR of bytes 1..7
//   Every byte is start(0), 8 data bits LSB first, stop(1); every bit lasts
//   CLKS_PER_BIT clocks, so a frame is 90*CLKS_PER_BIT clocks long.
//
// Ports
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset; forces the line high at once and
//        abandons any frame in flight
//   bus  uart_result_tx_if.slave: handshake, payload, tx line and status
//
// Parameters
//   CLK_FREQ      system clock frequency in Hz
//   BAUD_RATE     serial bit rate
//   CLKS_PER_BIT  clocks per serial bit (derived, must be >= 4)
// -----------------------------------------------------------------------------
module uart_result_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic             clk,
    input  logic             rst,
    uart_result_tx_if.slave  bus
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      HEADER    = 8'hA5;
    localparam logic [3:0]      LAST_BYTE = 4'd8;
    localparam logic [2:0]      LAST_BIT  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [7:0]       frame [0:8];
    logic [7:0]       cur_byte;
    logic             accept;
    logic             baud_end;

    logic             tx;
    logic             busy;
    logic             send_ready;
    logic             frame_done;

    // Status byte packs the halt indicator just above the five flags.
    function automatic logic [7:0] status_byte(input logic halt, input logic [4:0] flags);
        return {2'b00, halt, flags};
    endfunction

    // Checksum covers the payload bytes only, never the header.
    function automatic logic [7:0] checksum(
        input logic [15:0] res_hi,
        input logic [15:0] res_lo,
        input logic [15:0] op_p,
        input logic [7:0]  status
    );
        return res_hi[15:8] ^ res_hi[7:0] ^ res_lo[15:8] ^ res_lo[7:0]
             ^ op_p[15:8]   ^ op_p[7:0]   ^ status;
    endfunction

    assign accept   = (state == IDLE) && bus.send_valid;
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign cur_byte = frame[byte_idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and line/status decode. The line is decoded from registered
    // state, so the async reset of the state register drives it high at once.
    always_comb begin
        state_nxt  = state;
        tx         = 1'b1;
        busy       = 1'b0;
        send_ready = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                send_ready = 1'b1;
                if (bus.send_valid) begin
                    state_nxt = START;
                end
            end
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (baud_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx   = cur_byte[bit_idx];
                busy = 1'b1;
                if (baud_end && (bit_idx == LAST_BIT)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                busy = 1'b1;
                if (baud_end) begin
                    state_nxt = (byte_idx == LAST_BYTE) ? DONE : START;
                end
            end
            DONE: begin
                // A request seen here is dropped; ready only returns in IDLE.
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Baud, bit and byte counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                START, DATA, STOP: baud_cnt <= baud_end ? '0 : baud_cnt + CNT_W'(1);
                default:           baud_cnt <= '0;
            endcase

            // bit_idx wraps 7 -> 0 on its own, ready for the next byte.
            if ((state == DATA) && baud_end) begin
                bit_idx <= bit_idx + 3'd1;
            end else if (state == IDLE) begin
                bit_idx <= '0;
            end

            if ((state == STOP) && baud_end && (byte_idx != LAST_BYTE)) begin
                byte_idx <= byte_idx + 4'd1;
            end else if ((state == IDLE) || (state == DONE)) begin
                byte_idx <= '0;
            end
        end
    end

    // Frame buffer: captured once on accept, then held for the whole frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame[0] <= HEADER;
            frame[1] <= bus.result_high[15:8];
            frame[2] <= bus.result_high[7:0];
            frame[3] <= bus.result_low[15:8];
            frame[4] <= bus.result_low[7:0];
            frame[5] <= bus.operand_p[15:8];
            frame[6] <= bus.operand_p[7:0];
            frame[7] <= status_byte(bus.halt, bus.flags);
            frame[8] <= checksum(bus.result_high, bus.result_low, bus.operand_p,
                                 status_byte(bus.halt, bus.flags));
        end
    end

    assign bus.tx         = tx;
    assign bus.busy       = busy;
    assign bus.send_ready = send_ready;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_uart_result_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_result_tx
//   Directed bench for uart_result_tx at CLKS_PER_BIT = 10. Inputs are driven
//   and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_result_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_result_tx_if bus ();

    uart_result_tx #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int fmt_err  = 0;

    logic       cap [0:899];
    logic [7:0] got [0:8];

    // Hand-computed bytes for the first directed frame.
    logic [7:0] exp1 [0:8] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h9A, 8'hBC, 8'h35, 8'h1B};

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [15:0] rh, input logic [15:0] rl,
                         input logic [15:0] op, input logic [4:0] fl, input logic h);
        bus.result_high = rh;
        bus.result_low  = rl;
        bus.operand_p   = op;
        bus.flags       = fl;
        bus.halt        = h;
    endtask

    task automatic send(input logic [15:0] rh, input logic [15:0] rl,
                        input logic [15:0] op, input logic [4:0] fl, input logic h);
        drive(rh, rl, op, fl, h);
        bus.send_valid = 1'b1;
        tick();
        bus.send_valid = 1'b0;
    endtask

    // Expected frame, byte k in bits [8k +: 8].
    function automatic logic [71:0] model(input logic [15:0] rh, input logic [15:0] rl,
                                          input logic [15:0] op, input logic [4:0] fl,
                                          input logic h);
        logic [7:0] st;
        logic [7:0] ck;
        st = {2'b00, h, fl};
        ck = rh[15:8] ^ rh[7:0] ^ rl[15:8] ^ rl[7:0] ^ op[15:8] ^ op[7:0] ^ st;
        return {ck, st, op[7:0], op[15:8], rl[7:0], rl[15:8], rh[7:0], rh[15:8], 8'hA5};
    endfunction

    // Waits (bounded) for a start bit, records 900 line samples from its first
    // low cycle, then decodes bytes at bit centres.
    task automatic capture(output int start_cyc);
        int n;
        n = 0;
        start_cyc = -1;
        while (bus.tx !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        if (bus.tx !== 1'b0) begin
            check("start_timeout", 32'd0, 32'd1);
            for (int k = 0; k < 9; k++) got[k] = 8'h00;
            fmt_err = 1;
            return;
        end
        start_cyc = cyc;
        for (int i = 0; i < 900; i++) begin
            cap[i] = bus.tx;
            if (i != 899) tick();
        end
        fmt_err = 0;
        for (int k = 0; k < 9; k++) begin
            if (cap[k*100 + 5]  !== 1'b0) fmt_err++;
            if (cap[k*100 + 95] !== 1'b1) fmt_err++;
            for (int j = 0; j < 8; j++) got[k][j] = cap[k*100 + 10*(j+1) + 5];
        end
    endtask

    task automatic check_frame(input string tag, input logic [71:0] exp);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_b%0d", tag, k), {24'd0, got[k]}, {24'd0, exp[8*k +: 8]});
        check($sformatf("%s_framing", tag), fmt_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, lows, d0;
        logic [71:0] e;

        bus.send_valid = 1'b0;
        drive(16'h0, 16'h0, 16'h0, 5'h0, 1'b0);

        // Reset held for three cycles, then released.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx", bus.tx, 1);
            check("rst_ready", bus.send_ready, 1);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.frame_done, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold_tx", bus.tx, 1);
            check("hold_ready", bus.send_ready, 1);
            check("hold_busy", bus.busy, 0);
        end

        // Single frame with payload changes and an ignored request mid-frame.
        d0 = done_cnt;
        send(16'h1234, 16'h5678, 16'h9ABC, 5'b10101, 1'b1);
        check("accept_tx_low", bus.tx, 0);
        check("accept_busy", bus.busy, 1);
        check("accept_ready", bus.send_ready, 0);
        fork
            capture(s1);
            begin
                repeat (150) @(negedge clk);
                drive(16'hFFFF, 16'h0000, 16'h5555, 5'b01010, 1'b0);
                bus.send_valid = 1'b1;
                @(negedge clk);
                bus.send_valid = 1'b0;
            end
        join
        for (int k = 0; k < 9; k++)
            check($sformatf("f1_b%0d", k), {24'd0, got[k]}, {24'd0, exp1[k]});
        check("f1_framing", fmt_err, 0);
        lows = 0;
        for (int i = 0; i < 10; i++) if (cap[i] === 1'b0) lows++;
        check("start_len", lows, 10);
        check("lsb_first", cap[10], 1);
        check("bit1_of_hdr", cap[25], 0);
        tick();
        check("done_pulse", bus.frame_done, 1);
        check("done_busy", bus.busy, 0);
        check("done_tx", bus.tx, 1);
        tick();
        check("ready_after_done", bus.send_ready, 1);
        check("done_cleared", bus.frame_done, 0);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.tx !== 1'b1) lows++;
        end
        check("no_second_frame", lows, 0);
        #1;
        check("done_count", done_cnt - d0, 1);

        // Reset during the data bits of byte 3 (all zero), then a fresh frame.
        send(16'h4321, 16'h00EE, 16'h0001, 5'b00011, 1'b0);
        repeat (335) tick();
        check("pre_rst_tx", bus.tx, 0);
        rst = 1'b1;
        #1;
        check("rst_async_tx", bus.tx, 1);
        check("rst_async_busy", bus.busy, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", bus.send_ready, 1);
        check("post_rst_tx", bus.tx, 1);
        send(16'hBEEF, 16'hCAFE, 16'h0F0F, 5'b11000, 1'b1);
        capture(s1);
        check_frame("rr", model(16'hBEEF, 16'hCAFE, 16'h0F0F, 5'b11000, 1'b1));
        tick();
        tick();

        // Back-to-back frames with the request held high.
        drive(16'hA5A5, 16'h00FF, 16'h0F0F, 5'h1F, 1'b0);
        e = model(16'hA5A5, 16'h00FF, 16'h0F0F, 5'h1F, 1'b0);
        bus.send_valid = 1'b1;
        capture(s1);
        check_frame("bb1", e);
        capture(s2);
        bus.send_valid = 1'b0;
        check_frame("bb2", e);
        check("bb_gap", s2 - (s1 + 899), 3);
        tick();
        tick();
        check("bb_end_ready", bus.send_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
